// File: rtl/ps2_multi_key_decoder.sv
// PS/2 scan-code decoder that tracks up to 16 configured keys (make/break, E0-extended).
// Define PS2_KEY_LONGPRESS_EN to build the per-slot hold counters that drive long_press.
module ps2_multi_key_decoder #(
    parameter int unsigned               NUM_KEYS       = 4,
    parameter logic [9*NUM_KEYS-1:0]     KEY_CODES      = {9'h076, 9'h172, 9'h029, 9'h175},
    parameter int unsigned               TIMEOUT_CYCLES = 2500000,
    parameter int unsigned               HOLD_CYCLES    = 25000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] long_press,
    output logic                seq_err
);

    localparam int unsigned     TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         tmo_q;
    logic                  seq_err_q;
    logic [NUM_KEYS-1:0]   key_held_q, key_held_d;
    logic [NUM_KEYS-1:0]   key_press_q, key_press_d;
    logic [NUM_KEYS-1:0]   key_release_q, key_release_d;
    logic [NUM_KEYS-1:0]   slot_match;

    logic                  byte_e0, byte_f0, byte_ign;
    logic                  make_evt, brk_evt, tmo_evt;
    logic [8:0]            code;

    assign byte_e0  = (rx_data == 8'hE0);
    assign byte_f0  = (rx_data == 8'hF0);
    assign byte_ign = (rx_data == 8'hAA) || (rx_data == 8'hFA) ||
                      (rx_data == 8'hFE) || (rx_data == 8'hEE);

    // A received byte always takes precedence over an expiring prefix timeout.
    always_comb begin
        make_evt = 1'b0;
        brk_evt  = 1'b0;
        tmo_evt  = 1'b0;
        code     = {1'b0, rx_data};
        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!byte_e0 && !byte_f0 && !byte_ign) make_evt = 1'b1;
                end
                ST_EXT: begin
                    if (!byte_e0 && !byte_f0) begin
                        make_evt = 1'b1;
                        code     = {1'b1, rx_data};
                    end
                end
                ST_BRK: begin
                    brk_evt = 1'b1;
                end
                ST_EXT_BRK: begin
                    brk_evt = 1'b1;
                    code    = {1'b1, rx_data};
                end
                default: ;
            endcase
        end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
            tmo_evt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= tmo_evt;
            if (rx_valid || (state_q == ST_IDLE) || tmo_evt) tmo_q <= '0;
            else                                              tmo_q <= tmo_q + 1'b1;
            if (tmo_evt) begin
                state_q <= ST_IDLE;
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (byte_e0)      state_q <= ST_EXT;
                        else if (byte_f0) state_q <= ST_BRK;
                    end
                    ST_EXT: begin
                        if (byte_f0)       state_q <= ST_EXT_BRK;
                        else if (!byte_e0) state_q <= ST_IDLE;
                    end
                    ST_BRK:     state_q <= ST_IDLE;
                    ST_EXT_BRK: state_q <= ST_IDLE;
                    default:    state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        slot_match    = '0;
        key_held_d    = key_held_q;
        key_press_d   = '0;
        key_release_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            slot_match[i] = (KEY_CODES[9*i +: 9] == code);
            if (make_evt && slot_match[i] && !key_held_q[i]) begin
                key_held_d[i]  = 1'b1;
                key_press_d[i] = 1'b1;
            end
            if (brk_evt && slot_match[i] && key_held_q[i]) begin
                key_held_d[i]    = 1'b0;
                key_release_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_held_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            key_held_q    <= key_held_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

`ifdef PS2_KEY_LONGPRESS_EN
    localparam int unsigned     HW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_CYCLES);

    logic [HW-1:0]         hold_cnt_q [NUM_KEYS];
    logic [HW-1:0]         hold_cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]   long_press_q, long_press_d;

    // Counter restarts at zero on the press edge and saturates; repeats do not touch it.
    always_comb begin
        long_press_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hold_cnt_d[i] = '0;
            if (key_held_d[i] && key_held_q[i]) begin
                hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_MAX) ? hold_cnt_q[i] : hold_cnt_q[i] + 1'b1;
            end
            long_press_d[i] = key_held_d[i] && (hold_cnt_d[i] == HOLD_MAX);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            long_press_q <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) hold_cnt_q[i] <= '0;
        end else begin
            long_press_q <= long_press_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) hold_cnt_q[i] <= hold_cnt_d[i];
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = '0;
`endif

    assign key_held    = key_held_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign seq_err     = seq_err_q;

endmodule

// File: doc/ps2_multi_key_decoder.md
PS2_MULTI_KEY_DECODER -- requirements
Module: ps2_multi_key_decoder

Interface
REQ-001 Parameter NUM_KEYS, 4, number of tracked key slots (1..16).
REQ-002 Parameter KEY_CODES, {9'h076,9'h172,9'h029,9'h175}, packed 9 bits per slot: bit8 = E0-extended, bits7:0 = scan code; slot0 in LSBs (slot0 up-arrow E0 75, slot1 space 29, slot2 down-arrow E0 72, slot3 Esc 76).
REQ-003 Parameter TIMEOUT_CYCLES, 2500000, idle cycles (50 ms at 50 MHz) after which a partial prefix sequence is abandoned.
REQ-004 Parameter HOLD_CYCLES, 25000000, continuous-hold cycles (0.5 s) for long_press.
REQ-005 CLOCK_50  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_data  input  8  byte from the PS2_Controller received_data output.
REQ-008 rx_valid  input  1  one-cycle strobe, rx_data valid (PS2_Controller received_data_en).
REQ-009 key_held  output  NUM_KEYS  level, 1 while slot key is down.
REQ-010 key_press  output  NUM_KEYS  one-cycle pulse on slot make (not on typematic repeat).
REQ-011 key_release  output  NUM_KEYS  one-cycle pulse on slot break.
REQ-012 long_press  output  NUM_KEYS  level, slot held at least HOLD_CYCLES.
REQ-013 seq_err  output  1  one-cycle pulse when a prefix sequence times out.

Function
REQ-014 Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); bytes consumed only when rx_valid=1.
REQ-015 IDLE: E0->EXT, F0->BRK, AA/FA/FE/EE ignored (stay IDLE), other byte = make of {0,byte}, stay IDLE.
REQ-016 EXT: F0->EXT_BRK, E0 ignored (stay EXT), other byte = make of {1,byte} ->IDLE.
REQ-017 BRK: any byte = break of {0,byte} ->IDLE; EXT_BRK: any byte = break of {1,byte} ->IDLE.
REQ-018 Make/break compared in parallel against every slot of KEY_CODES; unmatched codes are discarded with no output change.
REQ-019 Make on slot with key_held=0: key_held and key_press asserted on the cycle after the final byte's rx_valid (latency 1).
REQ-020 Make on slot with key_held=1 (typematic repeat): no key_press, key_held stays 1, hold counter not restarted.
REQ-021 Break on slot with key_held=1: key_held cleared and key_release pulsed, latency 1; break on slot with key_held=0: ignored.
REQ-022 Multiple slots held concurrently and tracked independently; duplicate KEY_CODES entries update all matching slots identically.
REQ-023 Timeout counter clears on every rx_valid, counts while FSM not IDLE; reaching TIMEOUT_CYCLES-1 forces IDLE and pulses seq_err next cycle; rx_valid in that same cycle wins (byte processed, no seq_err).
REQ-024 key_press/key_release never both asserted for one slot in one cycle.

Reset
REQ-025 reset=1 forces FSM to IDLE and clears timeout counter, hold counters, key_held, key_press, key_release, long_press, seq_err to 0 on the next edge, including mid-sequence.
REQ-026 rx_valid during reset is discarded.

Configuration
REQ-027 Macro PS2_KEY_LONGPRESS_EN defined: per-slot saturating hold counter runs while key_held=1; long_press asserts the cycle counter reaches HOLD_CYCLES, clears with key_held.
REQ-028 Macro PS2_KEY_LONGPRESS_EN undefined: no hold counters instantiated, long_press tied 0, port still present.

Verification
REQ-029 Bytes E0,75 -> key_held[0]=1 and key_press[0] one pulse 1 cycle after second rx_valid; then E0,F0,75 -> key_held[0]=0, key_release[0] one pulse.
REQ-030 Bytes 29,29,29 (typematic) -> exactly one key_press[1] pulse, key_held[1]=1 throughout; F0,29 -> key_release[1].
REQ-031 Bytes 75 (no E0) -> no output change; E0,72 then 76 -> key_held=4'b1100; E0,F0,72 -> key_held=4'b1000.
REQ-032 Byte E0 then no byte for TIMEOUT_CYCLES (set 100 in bench) -> seq_err single pulse, FSM IDLE; following 29 -> key_press[1].
REQ-033 E0,75 then reset mid EXT of second sequence (E0 only) -> all outputs 0; after reset 76 -> key_press[3] only.
REQ-034 With PS2_KEY_LONGPRESS_EN, HOLD_CYCLES=50: hold 29 for 60 cycles -> long_press[1] rises at cycle 50 of hold, falls on F0,29; without macro long_press stays 0.
